// File: rtl/video_ch_requant.sv
// video_ch_requant
//   Re-quantises each channel of a streamed video pixel from S_CH_BITS to
//   M_CH_BITS. There are four modes: truncate, round with saturation,
//   per-channel LUT, and keep-low-bits. The pipeline is fixed at two
//   enabled cycles. A mode change is held pending and takes effect at the
//   next frame-start pixel. Each pixel carries its own mode through the
//   pipeline, so a frame never mixes modes.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   cke                      pipeline clock enable
//   in_update_req/param_mode request to adopt param_mode at next frame start
//   lut_we/lut_ch/lut_addr/lut_wdata  LUT write port (independent of cke)
//   s_*                      input pixel, mat sideband and user bits
//   m_*                      output pixel, mat sideband and user bits
//   active_mode              mode currently applied to new frames
//   update_ack               one-cycle pulse when a pending mode is adopted
module video_ch_requant #(
   parameter int         S_CH_BITS  = 10,
   parameter int         M_CH_BITS  = 8,
   parameter int         CH_DEPTH   = 3,
   parameter int         USER_BITS  = 1,
   parameter int         LUT_ENABLE = 1,
   parameter             RAM_TYPE   = "block",
   parameter logic [1:0] INIT_MODE  = 2'd0,
   localparam int        LCH_W      = (CH_DEPTH > 1) ? $clog2(CH_DEPTH) : 1
) (
   input  logic                            aresetn,
   input  logic                            aclk,
   input  logic                            cke,
   input  logic                            in_update_req,
   input  logic [1:0]                      param_mode,
   input  logic                            lut_we,
   input  logic [LCH_W-1:0]                lut_ch,
   input  logic [S_CH_BITS-1:0]            lut_addr,
   input  logic [M_CH_BITS-1:0]            lut_wdata,
   input  logic                            s_row_first,
   input  logic                            s_row_last,
   input  logic                            s_col_first,
   input  logic                            s_col_last,
   input  logic                            s_de,
   input  logic                            s_valid,
   input  logic [CH_DEPTH*S_CH_BITS-1:0]   s_data,
   input  logic [USER_BITS-1:0]            s_user,
   output logic                            m_row_first,
   output logic                            m_row_last,
   output logic                            m_col_first,
   output logic                            m_col_last,
   output logic                            m_de,
   output logic                            m_valid,
   output logic [CH_DEPTH*M_CH_BITS-1:0]   m_data,
   output logic [USER_BITS-1:0]            m_user,
   output logic [1:0]                      active_mode,
   output logic                            update_ack
);

   localparam int SH = S_CH_BITS - M_CH_BITS;
   // Rounding offset is half an output LSB; zero when no bits are dropped.
   localparam logic [S_CH_BITS:0] HALF =
      (SH == 0) ? '0 : ((S_CH_BITS+1)'(1) << ((SH == 0) ? 0 : SH - 1));
   localparam logic [S_CH_BITS:0] SAT = (S_CH_BITS+1)'((1 << M_CH_BITS) - 1);

   typedef enum logic {ST_IDLE, ST_PEND} upd_state_e;

   upd_state_e state_q, state_d;
   logic [1:0] pend_q, active_q, pix_mode;
   logic       ack_q, adopt, pend_load;
   logic       frame_start;

   assign frame_start = s_valid & s_row_first & s_col_first;

   // ---------------- update FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its inputs, independent of block order.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // ---------------- update FSM: next state ----------------
   // NOTE: a default assignment before the case means no path leaves
   // state_d unassigned, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (in_update_req) state_d = ST_PEND;
         // A request arriving on the adoption cycle opens a new pending period.
         ST_PEND: if (cke && frame_start && !in_update_req) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- update FSM: outputs ----------------
   always_comb begin
      adopt     = (state_q == ST_PEND) && cke && frame_start;
      pend_load = in_update_req;
   end

   // Request capture and the ack pulse run on every aclk edge. The active
   // mode can only move on an enabled frame-start edge because adopt
   // requires cke.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_q   <= INIT_MODE;
         active_q <= INIT_MODE;
         ack_q    <= 1'b0;
      end else begin
         if (pend_load) pend_q <= param_mode;
         if (adopt)     active_q <= pend_q;
         ack_q <= adopt;
      end
   end

   // The frame-start pixel itself already uses the newly adopted mode.
   assign pix_mode = adopt ? pend_q : active_q;

   // ---------------- stage 1 ----------------
   logic                          s1_valid_q;
   logic [4:0]                    s1_side_q;
   logic [USER_BITS-1:0]          s1_user_q;
   logic [CH_DEPTH*S_CH_BITS-1:0] s1_data_q;
   logic [1:0]                    s1_mode_q;
   logic [CH_DEPTH*M_CH_BITS-1:0] lut_rd;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s1_valid_q <= 1'b0;
         s1_side_q  <= '0;
         s1_user_q  <= '0;
         s1_data_q  <= '0;
         s1_mode_q  <= INIT_MODE;
      end else if (cke) begin
         s1_valid_q <= s_valid;
         s1_side_q  <= {s_de, s_row_first, s_row_last, s_col_first, s_col_last};
         s1_user_q  <= s_user;
         s1_data_q  <= s_data;
         s1_mode_q  <= pix_mode;
      end
   end

   if (LUT_ENABLE != 0) begin : g_lut
      for (genvar c = 0; c < CH_DEPTH; c++) begin : g_ch
         (* ram_style = RAM_TYPE *) logic [M_CH_BITS-1:0] mem [2**S_CH_BITS];
         logic [M_CH_BITS-1:0] rd_q;

         // NOTE: the table and its read register have no reset, so they map
         // onto RAM primitives; contents are defined only after being written.
         // Writes ignore cke so tables can be loaded while the pipe is stalled.
         always_ff @(posedge aclk) begin
            if (lut_we && (lut_ch == LCH_W'(c))) mem[lut_addr] <= lut_wdata;
         end

         // Read-before-write: a same-edge write to the same address is
         // not visible in rd_q until the next read.
         always_ff @(posedge aclk) begin
            if (cke) rd_q <= mem[s_data[c*S_CH_BITS +: S_CH_BITS]];
         end

         assign lut_rd[c*M_CH_BITS +: M_CH_BITS] = rd_q;
      end
   end else begin : g_no_lut
      assign lut_rd = '0;
   end

   // ---------------- stage 2 ----------------
   function automatic logic [M_CH_BITS-1:0] requant(
      input logic [1:0]           mode,
      input logic [S_CH_BITS-1:0] v,
      input logic [M_CH_BITS-1:0] lut_v
   );
      logic [S_CH_BITS:0]   sum;
      logic [S_CH_BITS:0]   shr;
      logic [M_CH_BITS-1:0] res;
      sum = {1'b0, v} + HALF;
      shr = sum >> SH;
      res = v[S_CH_BITS-1 -: M_CH_BITS];
      case (mode)
         2'd1:    res = (shr > SAT) ? SAT[M_CH_BITS-1:0] : shr[M_CH_BITS-1:0];
         2'd2:    if (LUT_ENABLE != 0) res = lut_v;
         2'd3:    res = v[M_CH_BITS-1:0];
         default: ;
      endcase
      return res;
   endfunction

   logic [CH_DEPTH*M_CH_BITS-1:0] m_data_d, m_data_q;
   logic [USER_BITS-1:0]          m_user_q;
   logic [4:0]                    m_side_q;
   logic                          m_valid_q;

   always_comb begin
      m_data_d = '0;
      if (s1_valid_q) begin
         for (int c = 0; c < CH_DEPTH; c++) begin
            m_data_d[c*M_CH_BITS +: M_CH_BITS] =
               requant(s1_mode_q, s1_data_q[c*S_CH_BITS +: S_CH_BITS],
                       lut_rd[c*M_CH_BITS +: M_CH_BITS]);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_valid_q <= 1'b0;
         m_side_q  <= '0;
         m_user_q  <= '0;
         m_data_q  <= '0;
      end else if (cke) begin
         m_valid_q <= s1_valid_q;
         m_side_q  <= s1_side_q;
         m_user_q  <= s1_valid_q ? s1_user_q : '0;
         m_data_q  <= m_data_d;
      end
   end

   assign m_valid     = m_valid_q;
   assign {m_de, m_row_first, m_row_last, m_col_first, m_col_last} = m_side_q;
   assign m_user      = m_user_q;
   assign m_data      = m_data_q;
   assign active_mode = active_q;
   assign update_ack  = ack_q;

endmodule

// File: tb/tb_video_ch_requant.sv
// Testbench for video_ch_requant (default parameters). The model derives
// every output from the mode rules on sampled inputs. It predicts each
// output two enabled cycles after input. Literal expectations pin the
// model on known vectors.
module tb_video_ch_requant;

   logic        aclk = 1'b0, aresetn = 1'b0, cke = 1'b0;
   logic        in_update_req = 1'b0;
   logic [1:0]  param_mode = 2'd0;
   logic        lut_we = 1'b0;
   logic [1:0]  lut_ch = 2'd0;
   logic [9:0]  lut_addr = '0;
   logic [7:0]  lut_wdata = '0;
   logic        s_row_first = 1'b0, s_row_last = 1'b0, s_col_first = 1'b0;
   logic        s_col_last = 1'b0, s_de = 1'b0, s_valid = 1'b0;
   logic [29:0] s_data = '0;
   logic [0:0]  s_user = '0;
   logic        m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid;
   logic [23:0] m_data;
   logic [0:0]  m_user;
   logic [1:0]  active_mode;
   logic        update_ack;

   video_ch_requant dut (
      .aresetn(aresetn), .aclk(aclk), .cke(cke),
      .in_update_req(in_update_req), .param_mode(param_mode),
      .lut_we(lut_we), .lut_ch(lut_ch), .lut_addr(lut_addr), .lut_wdata(lut_wdata),
      .s_row_first(s_row_first), .s_row_last(s_row_last),
      .s_col_first(s_col_first), .s_col_last(s_col_last),
      .s_de(s_de), .s_valid(s_valid), .s_data(s_data), .s_user(s_user),
      .m_row_first(m_row_first), .m_row_last(m_row_last),
      .m_col_first(m_col_first), .m_col_last(m_col_last),
      .m_de(m_de), .m_valid(m_valid), .m_data(m_data), .m_user(m_user),
      .active_mode(active_mode), .update_ack(update_ack)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0, n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        v, de, rf, rl, cf, cl;
      logic [23:0] d;
      logic        u;
   } beat_t;

   logic [7:0] lut_m [3][1024];
   beat_t      h0 = '0, h1 = '0, nb;
   logic [1:0] mdl_active = 2'd0, mdl_pend = 2'd0, md;
   bit         mdl_pending = 0;
   logic       mdl_ack = 1'b0;
   bit         en_prev = 0;

   function automatic logic [7:0] expect_ch(input logic [1:0] mode, input int c, input logic [9:0] v);
      int r;
      case (mode)
         2'd0: return 8'(v / 4);
         2'd1: begin
            r = (int'(v) + 2) / 4;
            return (r > 255) ? 8'd255 : 8'(r);
         end
         2'd2: return lut_m[c][v];
         default: return 8'(v % 256);
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge aclk or negedge aresetn);
         if (!aresetn) begin
            h0 = '0; h1 = '0;
            mdl_active = 2'd0; mdl_pend = 2'd0; mdl_pending = 0;
            mdl_ack = 1'b0; en_prev = 0;
         end else begin
            mdl_ack = 1'b0;
            en_prev = cke;
            if (cke) begin
               md = mdl_active;
               if (mdl_pending && s_valid && s_row_first && s_col_first) begin
                  md = mdl_pend; mdl_active = mdl_pend; mdl_pending = 0; mdl_ack = 1'b1;
               end
               nb = '0;
               nb.v = s_valid; nb.de = s_de; nb.rf = s_row_first; nb.rl = s_row_last;
               nb.cf = s_col_first; nb.cl = s_col_last;
               if (s_valid) begin
                  for (int k = 0; k < 3; k++) nb.d[k*8 +: 8] = expect_ch(md, k, s_data[k*10 +: 10]);
                  nb.u = s_user[0];
               end
               h1 = h0; h0 = nb;
            end
            if (in_update_req) begin mdl_pend = param_mode; mdl_pending = 1; end
            if (lut_we && lut_ch < 2'd3) lut_m[lut_ch][lut_addr] = lut_wdata;
         end
      end
   end

   // ---------------- compare process ----------------
   logic [23:0] last_fs = '0;
   int          ack_cnt = 0;
   logic [23:0] log_q[$], log_ref[$];

   initial begin
      forever begin
         @(negedge aclk);
         check("m_valid", m_valid, h1.v);
         check("m_side", {m_de, m_row_first, m_row_last, m_col_first, m_col_last},
               {h1.de, h1.rf, h1.rl, h1.cf, h1.cl});
         check("m_data", m_data, h1.d);
         check("m_user", m_user, h1.u);
         check("active_mode", active_mode, mdl_active);
         check("update_ack", update_ack, mdl_ack);
         if (m_valid && m_row_first && m_col_first) last_fs = m_data;
         if (update_ack) ack_cnt++;
         if (en_prev && m_valid) log_q.push_back(m_data);
      end
   end

   // ---------------- stimulus ----------------
   logic [31:0] cke_pat = 32'b1011_0010_1110_0101_0011_1001_0110_1101;
   bit          use_pat = 0;
   int          pidx = 0;

   // Holds one beat on the inputs until an enabled edge has consumed it.
   task automatic drive_beat(input logic v, input logic rf, input logic rl,
                             input logic cf, input logic cl,
                             input logic [29:0] d, input logic u);
      s_valid = v; s_de = v; s_row_first = rf; s_row_last = rl;
      s_col_first = cf; s_col_last = cl; s_data = d; s_user = u;
      forever begin
         cke = use_pat ? cke_pat[pidx % 32] : 1'b1;
         pidx++;
         @(negedge aclk);
         if (cke) break;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_beat(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   function automatic logic [29:0] pix(input int seed, input int idx);
      logic [29:0] d;
      for (int k = 0; k < 3; k++) d[k*10 +: 10] = 10'((seed*131 + idx*57 + k*311) % 1024);
      return d;
   endfunction

   task automatic mid_reset();
      #2 aresetn = 1'b0;
      #1;
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_side", {m_de, m_row_first, m_row_last, m_col_first, m_col_last}, 0);
      check("rst_active_mode", active_mode, 0);
      check("rst_update_ack", update_ack, 0);
      @(negedge aclk);
      @(negedge aclk);
      aresetn = 1'b1;
   endtask

   task automatic send_frame(input int rows, input int cols, input int seed,
                             input logic [29:0] first_d, input int req_at,
                             input logic [1:0] req_mode, input int rw_at, input int rst_at);
      int idx;
      logic [29:0] d;
      idx = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            d = (idx == 0) ? first_d : pix(seed, idx);
            if (idx == req_at) begin in_update_req = 1'b1; param_mode = req_mode; end
            if (idx == rw_at) begin
               lut_we = 1'b1; lut_ch = 2'd1; lut_addr = d[19:10]; lut_wdata = 8'h3C;
            end
            drive_beat(1'b1, r == 0, r == rows-1, c == 0, c == cols-1, d, c == 0);
            in_update_req = 1'b0; lut_we = 1'b0;
            if (idx == rst_at) mid_reset();
            idx++;
         end
         idle(1);
      end
   endtask

   initial begin
      repeat (2) @(negedge aclk);
      check("reset_m_valid", m_valid, 0);
      check("reset_m_data", m_data, 0);
      check("reset_active_mode", active_mode, 0);
      check("reset_update_ack", update_ack, 0);
      aresetn = 1'b1;

      // Load every table entry while cke toggles; loads must not depend on it.
      for (int c = 0; c < 3; c++) begin
         for (int a = 0; a < 1024; a++) begin
            lut_we = 1'b1; lut_ch = 2'(c); lut_addr = 10'(a);
            lut_wdata = 8'(a*3 + c*77 + (a >> 4)); cke = 1'(a % 2);
            @(negedge aclk);
         end
      end
      // Channel 3 does not exist: these writes must be dropped.
      for (int a = 0; a < 16; a++) begin
         lut_ch = 2'd3; lut_addr = 10'(a); lut_wdata = 8'hEE;
         @(negedge aclk);
      end
      lut_ch = 2'd2; lut_addr = 10'd5; lut_wdata = 8'hA5;
      @(negedge aclk);
      lut_we = 1'b0;
      idle(2);

      // Truncate (reset mode).
      send_frame(2, 4, 1, {10'h055, 10'h201, 10'h3FF}, -1, 2'd0, -1, -1);
      idle(3);
      check("trunc_ch0", last_fs[7:0], 8'hFF);
      check("trunc_ch1", last_fs[15:8], 8'h80);

      // Mid-frame request for round mode: must wait for the next frame.
      send_frame(3, 4, 2, pix(2, 0), 5, 2'd1, -1, -1);
      idle(3);
      check("midreq_active_held", active_mode, 0);
      check("midreq_no_ack", ack_cnt, 0);

      send_frame(2, 4, 3, {10'h001, 10'h002, 10'h3FE}, -1, 2'd0, -1, -1);
      idle(3);
      check("round_px", last_fs, 24'h0001FF);
      check("round_active", active_mode, 1);
      check("round_ack_once", ack_cnt, 1);

      // Request on the frame-start pixel while idle: adopted one frame later.
      send_frame(2, 4, 4, pix(4, 0), 0, 2'd2, -1, -1);
      idle(3);
      check("fs_req_active_held", active_mode, 1);
      check("fs_req_no_ack", ack_cnt, 1);

      // LUT frame with a same-edge read/write, and a request for mode 3.
      send_frame(2, 4, 5, {10'd5, 10'h100, 10'h2AA}, 7, 2'd3, 2, -1);
      idle(3);
      check("lut_ch2", last_fs[23:16], 8'hA5);
      check("lut_active", active_mode, 2);
      check("lut_ack_once", ack_cnt, 2);

      // Same 4x4 frame with cke=1 and with a stall pattern.
      log_q.delete();
      send_frame(4, 4, 9, pix(9, 0), -1, 2'd0, -1, -1);
      idle(3);
      check("bypass_active", active_mode, 3);
      log_ref = log_q;
      log_q.delete();
      use_pat = 1;
      send_frame(4, 4, 9, pix(9, 0), -1, 2'd0, -1, -1);
      idle(3);
      use_pat = 0;
      idle(1);
      check("cke_ref_len", log_ref.size(), 16);
      check("cke_pat_len", log_q.size(), 16);
      for (int i = 0; i < 16 && i < log_q.size() && i < log_ref.size(); i++)
         check("cke_pixel", log_q[i], log_ref[i]);

      // Reset in the middle of a frame, then resume.
      send_frame(4, 4, 11, pix(11, 0), -1, 2'd0, -1, 5);
      idle(3);
      check("post_rst_active", active_mode, 0);
      send_frame(2, 4, 12, pix(12, 0), -1, 2'd0, -1, -1);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/video_ch_requant.md
VIDEO_CH_REQUANT -- requirements
Module: video_ch_requant

Interface
REQ-001 Parameters SHALL be, with default and meaning:
- S_CH_BITS, 10, input channel width.
- M_CH_BITS, 8, output channel width; S_CH_BITS >= M_CH_BITS.
- CH_DEPTH, 3, channels per pixel.
- USER_BITS, 1, user sideband width.
- LUT_ENABLE, 1, builds per-channel gamma tables when 1.
- RAM_TYPE, "block", LUT RAM style.
- INIT_MODE, 2'd0, mode after reset.

REQ-002 Ports SHALL be, with direction, width and meaning:
- aresetn  in  1  asynchronous, active-low reset.
- aclk  in  1  single clock.
- cke  in  1  pipeline clock enable.
- in_update_req  in  1  request to adopt param_mode.
- param_mode  in  2  0=truncate, 1=round+saturate, 2=LUT, 3=bypass-low-bits.
- lut_we  in  1  LUT write strobe.
- lut_ch  in  $clog2(CH_DEPTH) (min 1)  LUT channel select.
- lut_addr  in  S_CH_BITS  LUT address.
- lut_wdata  in  M_CH_BITS  LUT write data.
- s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid  in  1 each  input mat sideband.
- s_data  in  CH_DEPTH*S_CH_BITS  input pixel, ch0 in LSBs.
- s_user  in  USER_BITS  input user sideband.
- m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid  out  1 each  output mat sideband.
- m_data  out  CH_DEPTH*M_CH_BITS  output pixel.
- m_user  out  USER_BITS  output user sideband.
- active_mode  out  2  mode currently applied.
- update_ack  out  1  one-cycle pulse when a mode is adopted.

Function
REQ-003 All registers except the LUT RAM SHALL advance only when cke=1; lut_we and update_req capture SHALL ignore cke.
REQ-004 Latency from s_* to m_* SHALL be exactly 2 enabled cycles in every mode; sideband and user SHALL be delayed identically to data.
REQ-005 Truncate mode: out = in[S_CH_BITS-1 -: M_CH_BITS].
REQ-006 Round mode: out = min((in + 2^(S_CH_BITS-M_CH_BITS-1)) >> (S_CH_BITS-M_CH_BITS), 2^M_CH_BITS-1); the sum SHALL be computed S_CH_BITS+1 wide; when S_CH_BITS==M_CH_BITS the result SHALL equal in.
REQ-007 LUT mode: out = LUT[ch][in]; read SHALL be registered in stage 1. If LUT_ENABLE=0, mode 2 SHALL behave as truncate.
REQ-008 Mode 3: out = in[M_CH_BITS-1:0].
REQ-009 A LUT write SHALL occur on any clock with lut_we=1; lut_ch >= CH_DEPTH SHALL be ignored; a same-cycle read/write to the same address SHALL return old data.
REQ-010 Update FSM states SHALL be IDLE and PEND.
- IDLE -> PEND on in_update_req=1; param_mode is latched into a pending register.
- PEND: a further in_update_req SHALL re-latch param_mode.
- PEND -> IDLE on the enabled cycle where s_valid & s_row_first & s_col_first; the pending mode is copied to the active mode and applies to that pixel; update_ack pulses for one aclk cycle.
REQ-011 If in_update_req coincides with a frame-start pixel while in IDLE, adoption SHALL wait for the next frame start.
REQ-012 The active mode SHALL never change mid-frame; the pixel pipeline SHALL carry the mode with each pixel so that in-flight pixels keep their mode.
REQ-013 m_data and m_user SHALL be don't-care when m_valid=0, but deterministic in simulation (driven 0).

Reset
REQ-014 On aresetn=0 asynchronously:
- m_valid, m_de, m_row_first, m_row_last, m_col_first, m_col_last, update_ack = 0.
- m_data and m_user = 0.
- active_mode = INIT_MODE; FSM = IDLE.
- LUT contents are not reset.
REQ-015 Reset release mid-frame SHALL resume with m_valid=0 until valid input has propagated 2 enabled cycles.

Verification
REQ-016 Truncate mode, s_data ch0=10'h3FF, ch1=10'h201 -> m_data ch0=8'hFF, ch1=8'h80, appearing 2 cycles later.
REQ-017 Round mode, inputs 10'h3FE, 10'h002, 10'h001 -> outputs 8'hFF (saturated), 8'h01, 8'h00.
REQ-018 Write LUT ch2 addr 5 = 8'hA5, select LUT mode, frame start with ch2=5 -> m_data ch2=8'hA5 and update_ack pulses once.
REQ-019 in_update_req asserted mid-frame -> active_mode unchanged until next s_row_first&s_col_first pixel; earlier pixels keep the old mode.
REQ-020 cke toggled 0/1 randomly with a 4x4 frame -> output sequence identical to cke=1 run; no pixel lost or duplicated.
REQ-021 aresetn pulsed low mid-frame -> all outputs 0 immediately; active_mode=INIT_MODE.
